// File: rtl/led_pwm_pkg.sv
// Shared types for the LED PWM array: channel mode encoding and its width.
package led_pwm_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

endpackage

// File: rtl/led_pwm_array_if.sv
// Configuration write port: valid/ready handshake carrying channel, mode and duty.
interface led_pwm_array_if #(
  parameter int DUTY_W = 8
);
  import led_pwm_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [3:0]        wr_addr;
  mode_e             wr_mode;
  logic [DUTY_W-1:0] wr_duty;

  modport master (output wr_valid, wr_addr, wr_mode, wr_duty, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_mode, wr_duty, output wr_ready);

endinterface

// File: rtl/pwm_timebase.sv
// Shared timebase: free-running dim counter, blink prescaler, blink phase and period-wrap strobe.
module pwm_timebase #(
  parameter int DUTY_W    = 8,
  parameter int BLINK_DIV = 1 << 22
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  output logic [DUTY_W-1:0] dim_cnt_o,
  output logic              blink_tick_o,
  output logic              blink_ph_o,
  output logic              period_wrap_o
);

  localparam int                PRE_W   = $clog2(BLINK_DIV);
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(BLINK_DIV - 1);

  logic [DUTY_W-1:0] dim_cnt_q;
  logic [PRE_W-1:0]  pre_q;
  logic              blink_ph_q;

  // Both strobes are high on the cycle before their counter wraps, so state
  // keyed off them changes on the same edge the counter returns to 0.
  assign blink_tick_o  = (pre_q == PRE_MAX);
  assign period_wrap_o = &dim_cnt_q;
  assign dim_cnt_o     = dim_cnt_q;
  assign blink_ph_o    = blink_ph_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      dim_cnt_q  <= '0;
      pre_q      <= '0;
      blink_ph_q <= 1'b1;
    end else begin
      dim_cnt_q <= dim_cnt_q + DUTY_W'(1);
      pre_q     <= blink_tick_o ? '0 : pre_q + PRE_W'(1);
      if (blink_tick_o) begin
        blink_ph_q <= ~blink_ph_q;
      end
    end
  end

endmodule

// File: rtl/led_pwm_array.sv
// Per-channel PWM LED driver (OFF/ON/BLINK) with a one-deep write shadow applied at period wrap.
// BREATHE mode and its level/direction state are built only when LED_PWM_BREATHE_EN is defined.
module led_pwm_array
  import led_pwm_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DUTY_W    = 8,
  parameter int BLINK_DIV = 1 << 22
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] en,
  led_pwm_array_if.slave      wr,
  output logic [CHANNELS-1:0] led_n
);

  logic [DUTY_W-1:0]   dim_cnt;
  logic                blink_ph;
  logic                period_wrap;

  mode_e               mode_q    [CHANNELS];
  logic [DUTY_W-1:0]   duty_q    [CHANNELS];
  logic [DUTY_W-1:0]   eff_duty  [CHANNELS];
  logic                pend_q;
  logic [3:0]          sh_addr_q;
  mode_e               sh_mode_q;
  logic [DUTY_W-1:0]   sh_duty_q;
  logic [CHANNELS-1:0] led_n_q;
  logic [CHANNELS-1:0] led_n_d;
  logic [CHANNELS-1:0] hit;
  logic                accept;
  logic                apply;

`ifdef LED_PWM_BREATHE_EN
  logic                blink_tick;
  logic [DUTY_W-1:0]   level_q [CHANNELS];
  logic [CHANNELS-1:0] fall_q;
  logic [CHANNELS-1:0] up_c;
`endif

  pwm_timebase #(
    .DUTY_W    (DUTY_W),
    .BLINK_DIV (BLINK_DIV)
  ) u_timebase (
    .clk_i         (clk),
    .reset_ni      (reset),
    .dim_cnt_o     (dim_cnt),
`ifdef LED_PWM_BREATHE_EN
    .blink_tick_o  (blink_tick),
`else
    .blink_tick_o  (),
`endif
    .blink_ph_o    (blink_ph),
    .period_wrap_o (period_wrap)
  );

  // Out-of-range addresses complete the handshake but never occupy the shadow.
  assign wr.wr_ready = !pend_q;
  assign accept      = wr.wr_valid && !pend_q && ({1'b0, wr.wr_addr} < 5'(CHANNELS));
  assign apply       = pend_q && period_wrap;

  always_comb begin
    hit = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      hit[ch] = apply && (sh_addr_q == 4'(ch));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q    <= 1'b0;
      sh_addr_q <= '0;
      sh_mode_q <= MODE_OFF;
      sh_duty_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        mode_q[ch] <= MODE_OFF;
        duty_q[ch] <= '0;
      end
    end else begin
      if (accept) begin
        pend_q    <= 1'b1;
        sh_addr_q <= wr.wr_addr;
        sh_mode_q <= wr.wr_mode;
        sh_duty_q <= wr.wr_duty;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (hit[ch]) begin
          mode_q[ch] <= sh_mode_q;
          duty_q[ch] <= sh_duty_q;
        end
      end
    end
  end

`ifdef LED_PWM_BREATHE_EN
  // Step direction: climb toward duty, descend toward 0, turning at either end.
  always_comb begin
    up_c = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      up_c[ch] = fall_q[ch] ? (level_q[ch] == '0) : (level_q[ch] != duty_q[ch]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fall_q <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        level_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (hit[ch]) begin
          if (sh_mode_q != mode_q[ch]) begin
            level_q[ch] <= '0;
            fall_q[ch]  <= 1'b0;
          end
        end else if (blink_tick && (mode_q[ch] == MODE_BREATHE)) begin
          if (level_q[ch] > duty_q[ch]) begin
            level_q[ch] <= duty_q[ch];
            fall_q[ch]  <= 1'b1;
          end else if (duty_q[ch] != '0) begin
            if (up_c[ch]) begin
              level_q[ch] <= level_q[ch] + DUTY_W'(1);
              fall_q[ch]  <= ((level_q[ch] + DUTY_W'(1)) == duty_q[ch]);
            end else begin
              level_q[ch] <= level_q[ch] - DUTY_W'(1);
              fall_q[ch]  <= (level_q[ch] != DUTY_W'(1));
            end
          end
        end
      end
    end
  end
`endif

  always_comb begin
    led_n_d = '1;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      eff_duty[ch] = '0;
      case (mode_q[ch])
        MODE_ON, MODE_BLINK: eff_duty[ch] = duty_q[ch];
`ifdef LED_PWM_BREATHE_EN
        MODE_BREATHE:        eff_duty[ch] = level_q[ch];
`endif
        default:             eff_duty[ch] = '0;
      endcase
      led_n_d[ch] = !(en[ch] && (dim_cnt < eff_duty[ch]) &&
                      ((mode_q[ch] != MODE_BLINK) || blink_ph));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_n_q <= '1;
    end else begin
      led_n_q <= led_n_d;
    end
  end

  assign led_n = led_n_q;

endmodule

// File: tb/tb_led_pwm_array.sv
// Directed bench for led_pwm_array (CHANNELS=4, DUTY_W=4, BLINK_DIV=8); n counts edges since reset release.
module tb_led_pwm_array;
  import led_pwm_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] en    = 4'b0000;
  logic [3:0] led_n;
  int         n = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         lit;
  int         lvl_exp [8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  always #5 clk = ~clk;

  led_pwm_array_if #(.DUTY_W(4)) wr_if ();

  led_pwm_array #(
    .CHANNELS  (4),
    .DUTY_W    (4),
    .BLINK_DIV (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .wr    (wr_if),
    .led_n (led_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
    end
  endtask

  task automatic steps(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic go_to(input int t);
    steps(t - n);
  endtask

  task automatic put(input logic [3:0] a, input mode_e m, input logic [3:0] d);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = a;
    wr_if.wr_mode  = m;
    wr_if.wr_duty  = d;
  endtask

  initial begin
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = 4'd0;
    wr_if.wr_mode  = MODE_OFF;
    wr_if.wr_duty  = 4'd0;

    steps(3);
    chk("rst_led", led_n, 4'hF);
    chk("rst_rdy", wr_if.wr_ready, 1);
    reset = 1'b1;
    n = 0;

    // ch0 ON duty 4: applied at edge 16, lit for dim 0..3
    put(4'd0, MODE_ON, 4'd4);
    en = 4'b0001;
    steps(1);
    wr_if.wr_valid = 1'b0;
    chk("acc_rdy_lo", wr_if.wr_ready, 0);
    go_to(16);
    chk("pre_bound_dark", led_n, 4'hF);
    chk("rdy_after_wrap", wr_if.wr_ready, 1);
    go_to(17);
    chk("on_first_lit", led_n, 4'hE);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      lit += (led_n == 4'hE) ? 1 : 0;
      steps(1);
    end
    chk("on_lit_count", lit, 4);

    // en takes effect one clock later in both directions
    en = 4'b0011;
    steps(1);
    chk("en_on", led_n, 4'hE);
    en = 4'b0010;
    steps(1);
    chk("en_off", led_n, 4'hF);

    // ch1 BLINK duty 15: applied at edge 48
    put(4'd1, MODE_BLINK, 4'd15);
    steps(1);
    wr_if.wr_valid = 1'b0;
    go_to(49);
    chk("blink_first", led_n, 4'hD);
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      lit += led_n[1] ? 0 : 1;
      steps(1);
    end
    chk("blink_lit_win", lit, 8);
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      lit += led_n[1] ? 0 : 1;
      steps(1);
    end
    chk("blink_dark_win", lit, 0);
    chk("blink_relit", led_n, 4'hD);

    // back-to-back writes with wr_valid held
    put(4'd0, MODE_OFF, 4'd0);
    steps(1);
    chk("b2b_rdy_66", wr_if.wr_ready, 0);
    put(4'd3, MODE_ON, 4'd15);
    go_to(79);
    chk("b2b_rdy_79", wr_if.wr_ready, 0);
    steps(1);
    chk("b2b_rdy_80", wr_if.wr_ready, 1);
    steps(1);
    chk("b2b_rdy_81", wr_if.wr_ready, 0);
    wr_if.wr_valid = 1'b0;
    en = 4'b1001;
    go_to(90);
    chk("ch0_off", led_n, 4'hF);
    go_to(97);
    chk("ch3_on", led_n, 4'h7);
    go_to(111);
    chk("duty15_dim14", led_n, 4'h7);
    go_to(112);
    chk("duty15_dim15", led_n, 4'hF);

    // out-of-range address is dropped
    put(4'd5, MODE_ON, 4'd15);
    en = 4'b1111;
    steps(1);
    chk("oor_rdy", wr_if.wr_ready, 1);
    wr_if.wr_valid = 1'b0;
    go_to(129);
    chk("oor_state_lit", led_n, 4'h5);
    go_to(137);
    chk("oor_state_dark", led_n, 4'h7);

    // ch2 BREATHE duty 3: applied at edge 144, ticks every 8 edges
    put(4'd2, MODE_BREATHE, 4'd3);
    steps(1);
    wr_if.wr_valid = 1'b0;
`ifdef LED_PWM_BREATHE_EN
    for (int i = 0; i < 8; i++) begin
      go_to(145 + 8 * i);
      chk("breathe_level", dut.level_q[2], lvl_exp[i]);
    end
`else
    go_to(145);
    lit = 0;
    for (int i = 0; i < 56; i++) begin
      lit += led_n[2] ? 0 : 1;
      steps(1);
    end
    chk("breathe_off_dark", lit, 0);
`endif

    // duty 0 pulls level down and holds it at 0
    put(4'd2, MODE_BREATHE, 4'd0);
    steps(1);
    wr_if.wr_valid = 1'b0;
`ifdef LED_PWM_BREATHE_EN
    go_to(217);
    chk("duty0_217", dut.level_q[2], 0);
    go_to(225);
    chk("duty0_225", dut.level_q[2], 0);
    go_to(241);
    chk("duty0_241", dut.level_q[2], 0);
`else
    go_to(217);
    lit = 0;
    for (int i = 0; i < 24; i++) begin
      lit += led_n[2] ? 0 : 1;
      steps(1);
    end
    chk("duty0_off_dark", lit, 0);
`endif

    // reset mid-write aborts the pending write
    put(4'd0, MODE_ON, 4'd15);
    steps(1);
    chk("rst_wr_pend", wr_if.wr_ready, 0);
    wr_if.wr_valid = 1'b0;
    steps(3);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_led", led_n, 4'hF);
    chk("rst_async_rdy", wr_if.wr_ready, 1);
    steps(2);
    reset = 1'b1;
    n = 0;
    go_to(17);
    chk("post_rst_dark", led_n, 4'hF);
    chk("post_rst_rdy", wr_if.wr_ready, 1);
    go_to(20);
    chk("post_rst_dark2", led_n, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
